// File: rtl/hit_judge.sv
// Per-column hit/miss judge: key synchroniser + edge detect, IDLE/ARMED/COOL FSM,
// saturating score and combo counters. Response lands 3 edges after a KEY rise.
module hit_judge #(
   parameter int SCORE_W  = 10,
   parameter int COMBO_W  = 7,
   parameter int BONUS_AT = 8
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               CLEAR,
   input  logic               KEY,
   input  logic               TARGET,
   output logic               GOTCHA,
   output logic               MISS,
   output logic [SCORE_W-1:0] SCORE,
   output logic [COMBO_W-1:0] COMBO
);

   typedef enum logic [1:0] {IDLE, ARMED, COOL} state_t;

   state_t             state;
   logic               s1, s2, s3;
   logic               press;
   logic               hit, miss;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_next;
   logic [COMBO_W-1:0] combo_next;

   // s1/s2 double as the synchroniser for the raw key; s3 gives the edge detect
   assign press = s2 & ~s3;

   always_comb begin
      hit  = 1'b0;
      miss = 1'b0;
      case (state)
         IDLE: begin
            hit  = TARGET & press;
            miss = ~TARGET & press;
         end
         ARMED: begin
            hit  = press;
            miss = ~TARGET & ~press;
         end
         default: ;
      endcase
   end

   // bonus is chosen from the combo before this hit increments it
   assign score_sum  = {1'b0, SCORE} +
                       ((int'(COMBO) >= BONUS_AT) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
   assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign combo_next = (&COMBO) ? COMBO : COMBO + COMBO_W'(1);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         GOTCHA <= 1'b0;
         MISS   <= 1'b0;
         SCORE  <= '0;
         COMBO  <= '0;
      end else if (CLEAR) begin
         state  <= IDLE;
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         GOTCHA <= 1'b0;
         MISS   <= 1'b0;
         SCORE  <= '0;
         COMBO  <= '0;
      end else begin
         s1     <= KEY;
         s2     <= s1;
         s3     <= s2;
         GOTCHA <= hit;
         MISS   <= miss;
         if (hit) begin
            SCORE <= score_next;
            COMBO <= combo_next;
         end else if (miss) begin
            COMBO <= '0;
         end
         case (state)
            IDLE: begin
               if (hit)         state <= COOL;
               else if (TARGET) state <= ARMED;
            end
            ARMED: begin
               if (hit)       state <= COOL;
               else if (miss) state <= IDLE;
            end
            COOL: begin
               // the light dropping during GOTCHA is absorbed here, never a miss
               if (!TARGET) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hit_judge.md
# hit_judge

Per-column judge that sits directly downstream of the target-row light. It watches the lit target and the player's key for that column and decides hit or miss. On a hit it issues the one-cycle GOTCHA pulse that clears the target light. It also keeps the column's running score and combo count for the display and scoreboard logic.

## Interface
Parameters:
- SCORE_W, 10: width of SCORE.
- COMBO_W, 7: width of COMBO.
- BONUS_AT, 8: once COMBO is at or above this value, each hit scores 2 instead of 1.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset; clears all state immediately.
- CLEAR  input  1  synchronous new-game clear; same effect as RESET, applied at the clock edge.
- KEY  input  1  raw, asynchronous player key for this column; high means pressed.
- TARGET  input  1  target-row light for this column (LIGHTON of the target light).
- GOTCHA  output  1  registered one-cycle hit pulse; drives the target light's clear.
- MISS  output  1  registered one-cycle miss pulse.
- SCORE  output  SCORE_W  accumulated score; unsigned, saturating.
- COMBO  output  COMBO_W  consecutive hits since the last miss; unsigned, saturating.

## Operation
Key front end:
- KEY passes through a 3-flop chain s1 → s2 → s3.
- PRESS = s2 & ~s3, one cycle per rising edge of KEY.
- A held key produces exactly one PRESS.

State machine (registered states IDLE, ARMED, COOL):
- IDLE:
  - TARGET=1 and PRESS → hit, go COOL.
  - TARGET=1 and no PRESS → ARMED.
  - TARGET=0 and PRESS → early press: MISS, stay IDLE.
  - Otherwise stay IDLE.
- ARMED:
  - PRESS → hit, go COOL.
  - TARGET=0 and no PRESS → late miss: MISS, go IDLE.
  - Otherwise stay ARMED.
- COOL:
  - PRESS is ignored (no MISS, no score).
  - TARGET=0 → IDLE; TARGET=1 → stay COOL.
  - A target that relights while in COOL is not scored twice.

Hit effects, all at the same edge:
- GOTCHA=1 for the next cycle.
- SCORE += (COMBO ≥ BONUS_AT) ? 2 : 1, using the pre-increment COMBO.
- COMBO += 1.

Miss effects:
- MISS=1 for the next cycle.
- COMBO → 0. SCORE is unchanged.

Arithmetic:
- SCORE saturates at 2^SCORE_W−1; an add that would overflow clamps to the maximum.
- COMBO saturates at 2^COMBO_W−1.
- GOTCHA and MISS are never high in the same cycle.

## Timing
Reset values (on RESET high, asynchronously):
- GOTCHA=0, MISS=0, SCORE=0, COMBO=0.
- State IDLE; s1, s2, s3 = 0.

CLEAR:
- Produces the same values at the next edge.
- Takes priority over any hit or miss evaluated in that cycle.

Latency:
- KEY rises before edge k → s1=1 after k, s2=1 after k+1, PRESS true during cycle k+1..k+2.
- GOTCHA or MISS and the SCORE/COMBO update are visible after edge k+2.
- Total: 3 edges from KEY to response.
- Late miss: TARGET low sampled at edge m while ARMED → MISS high after m, for one cycle.

Reset or CLEAR mid-operation:
- ARMED or COOL state is abandoned and pulses are suppressed.
- A key held through reset release yields one PRESS, judged 2 edges after release (early-press MISS if TARGET=0).

GOTCHA clears the target asynchronously:
- TARGET may fall during the GOTCHA cycle.
- COOL absorbs this fall without a MISS.

## Test plan
- Reset, then idle 10 cycles with KEY=0, TARGET=0 → all outputs 0, no pulses.
- TARGET high from cycle 5; KEY rises before edge 8 → GOTCHA high only after edge 10; SCORE=1; COMBO=1; MISS never asserted.
- TARGET high 6 cycles then low, KEY never pressed → one MISS pulse after the falling-edge sample; COMBO=0; SCORE unchanged.
- KEY pressed with TARGET=0 → MISS after 3 edges; a second press while held (no re-press) produces nothing; pressing 3 times in COOL with TARGET=1 → no MISS, SCORE unchanged.
- 12 consecutive hits from reset → SCORE = 8×1 + 4×2 = 16; COMBO=12; then one late miss → COMBO=0, SCORE=16.
- SCORE_W=4: 20 hits → SCORE clamps at 15. RESET pulsed while ARMED → all outputs 0 immediately, state IDLE, no GOTCHA.
